// File: rtl/calc_alu_sequencer_if.sv
// Request/response handshake bundle between the calculator front end and the ALU sequencer.
interface calc_alu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle ALU: one-cycle pass/add/sub, shift-add multiply, and a restoring divider
// that is present only when CALC_ALU_SEQ_DIV_EN is defined (otherwise opcode 100 is illegal).
module calc_alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    calc_alu_sequencer_if.slave bus,
    output logic                busy
);
    localparam int CW = $clog2(WIDTH);

`ifdef CALC_ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SIMPLE, MUL, DIV, DIVFIX, DONE} state_t;

    state_t           state, state_next;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             neg;
    logic [WIDTH-1:0] hi, lo, mc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic             err;
    logic             last;
    logic [WIDTH-1:0] mul_sum;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign last    = (cnt == CW'(WIDTH - 1));
    assign mul_sum = hi + (lo[0] ? mc : '0);

`ifdef CALC_ALU_SEQ_DIV_EN
    // Trial subtraction of the divisor from the shifted remainder; the top bit is the borrow.
    logic [WIDTH:0] div_diff;
    assign div_diff = {hi, lo[WIDTH-1]} - {1'b0, mc};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_op == 3'b101)                state_next = MUL;
                    else if (bus.req_op == 3'b100 && DIV_EN) state_next = DIV;
                    else                                     state_next = SIMPLE;
                end
            end
            SIMPLE:  state_next = DONE;
            MUL:     if (last) state_next = DONE;
`ifdef CALC_ALU_SEQ_DIV_EN
            DIV: begin
                if (b == '0)   state_next = DONE;
                else if (last) state_next = DIVFIX;
            end
            DIVFIX:  state_next = DONE;
`endif
            DONE:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= '0;
            a      <= '0;
            b      <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mc     <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (clr) begin
            result <= '0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op  <= bus.req_op;
                        a   <= bus.req_a;
                        b   <= bus.req_b;
                        neg <= bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1];
                        hi  <= '0;
                        cnt <= '0;
                        // Multiply: mc = multiplicand, lo = multiplier. Divide: lo = dividend, mc = divisor.
                        if (bus.req_op == 3'b101) begin
                            mc <= mag(bus.req_a);
                            lo <= mag(bus.req_b);
                        end else begin
                            lo <= mag(bus.req_a);
                            mc <= mag(bus.req_b);
                        end
                    end
                end
                SIMPLE: begin
                    err <= 1'b0;
                    case (op)
                        3'b000, 3'b001: result <= b;
                        3'b010:         result <= a + b;
                        3'b011:         result <= a - b;
                        default: begin
                            result <= '0;
                            err    <= 1'b1;
                        end
                    endcase
                end
                MUL: begin
                    hi  <= mul_sum;
                    mc  <= mc << 1;
                    lo  <= lo >> 1;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result <= neg ? -mul_sum : mul_sum;
                        err    <= 1'b0;
                    end
                end
`ifdef CALC_ALU_SEQ_DIV_EN
                DIV: begin
                    if (b == '0) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        hi  <= div_diff[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : div_diff[WIDTH-1:0];
                        lo  <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
                        cnt <= cnt + CW'(1);
                    end
                end
                DIVFIX: begin
                    result <= neg ? -lo : lo;
                    err    <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.resp_valid  = (state == DONE);
    assign bus.resp_result = result;
    assign bus.resp_err    = err;
    assign busy            = (state != IDLE);
endmodule

// File: doc/calc_alu_sequencer.md
# calc_alu_sequencer

Multi-cycle ALU controller for the calculator datapath. It accepts one operation request at a time from the keypad/state-machine front end over a valid/ready handshake, and runs the operation. Add, subtract and pass complete in one cycle. Multiply uses an iterative shift-add engine and divide uses an iterative restoring divider. The block returns a registered result with an error flag, so the front end no longer needs combinational 32-bit multiply/divide.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (two's complement)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- clr  input  1  synchronous abort; returns to IDLE, discards any in-flight operation
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; request accepted on clk edge with req_valid & req_ready
- req_op  input  3  opcode: 000/001 pass b, 010 add, 011 sub, 100 div, 101 mul, 110/111 illegal
- req_a  input  WIDTH  operand a (signed)
- req_b  input  WIDTH  operand b (signed)
- resp_valid  output  1  result available; held until accepted
- resp_ready  input  1  consumer takes result on edge with resp_valid & resp_ready
- resp_result  output  WIDTH  result, stable while resp_valid
- resp_err  output  1  divide-by-zero or illegal opcode
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, SIMPLE, MUL, DIV, DIVFIX, DONE.
- IDLE: req_ready=1. On accept, the block latches op, a and b, then goes to SIMPLE (000,001,010,011,110,111), MUL (101) or DIV (100).
- SIMPLE: pass → b; add → a+b; sub → a−b; illegal → result 0, err=1. Wraps modulo 2^WIDTH with no overflow flag. Goes to DONE.
- MUL: works on magnitudes with a 5-bit counter (log2 WIDTH). Each cycle: if multiplier LSB is set, add the shifted multiplicand; shift. After WIDTH iterations, the sign is applied as a^b sign bit. Result is the low WIDTH bits of the signed product. Goes to DONE.
- DIV: if b==0, the block goes directly to DONE with result 0 and err=1 (1 cycle). Otherwise it runs a restoring division on magnitudes for WIDTH iterations, then goes to DIVFIX.
- DIVFIX: negates the quotient when sign(a)≠sign(b), so quotient truncates toward zero. The remainder is discarded. Goes to DONE.
- DONE: resp_valid=1. On resp_ready, returns to IDLE. A new request can be accepted no earlier than the following cycle.
- clr, in any state: next state is IDLE, resp_valid=0, result and err cleared. clr has priority over both handshakes in the same cycle.
- The −2^(WIDTH−1) / −1 case yields −2^(WIDTH−1) with err=0.

## Timing
- Reset (rst=0, asynchronous): state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, busy=0. Counters and operand registers are cleared.
- If reset asserts mid-operation, the operation is lost and no response is produced.
- Latency is measured from the accept edge k to the edge after which resp_valid=1:
  - pass/add/sub/illegal: k+1
  - div by zero: k+1
  - mul: k+WIDTH (32)
  - div: k+WIDTH+1 (33)
- resp_result and resp_err change only on the edge entering DONE, on clr, or on reset.
- Minimum back-to-back throughput for simple ops is one operation per 3 cycles: accept, SIMPLE, DONE/ack.
- Inputs req_a, req_b and req_op are sampled only on the accept edge. Changes while busy are ignored.

## Configuration
- CALC_ALU_SEQ_DIV_EN: when defined, the DIV and DIVFIX states and the divider datapath are compiled in.
- Without CALC_ALU_SEQ_DIV_EN, opcode 100 is treated as illegal: it goes via SIMPLE, giving result 0, err=1, latency k+1. The DIV/DIVFIX encodings are unused.

## Test plan
- Reset then add: a=7, b=5, op=010 → resp_valid at k+1, result 12, err 0. With resp_ready held low for 4 cycles, result stays 12 and req_ready stays 0.
- Signed multiply: a=−3, b=12, op=101 → resp_valid at k+32, result −36 (0xFFFFFFDC). Also a=0x10000, b=0x10000 → result 0 (wrap).
- Divide with macro defined: a=−17, b=5, op=100 → resp_valid at k+33, result −3, err 0. Also b=0 → k+1, result 0, err 1.
- Macro undefined: a=10, b=2, op=100 → k+1, result 0, err 1. Also op=111 → result 0, err 1.
- Abort and reset: clr pulsed at k+10 of a mul → IDLE next cycle, resp_valid never rises, busy=0. Then rst=0 asserted asynchronously mid-div → all outputs at reset values before the next clk edge.
- Handshake: req_valid held high continuously with sub a=1, b=3 → each result −2 is accepted exactly once per accept, and no request is accepted while busy.
